// File: rtl/display_pkg.sv
// Shared types, segment codes and the double-dabble nibble adjust used by
// the GPIO decimal display.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      LATCH = 2'd2
   } disp_state_t;

   // Active-low seven-segment codes, bit0 = a ... bit6 = g.
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // A BCD nibble of 5 or more would exceed 9 after doubling, so it is
   // pre-corrected by 3 before the shift.
   function automatic logic [3:0] add3(input logic [3:0] nib);
      return (nib >= 4'd5) ? (nib + 4'd3) : nib;
   endfunction

endpackage

// File: rtl/bcd_seg7.sv
// One BCD nibble to an active-low seven-segment pattern, with forced blank.
module bcd_seg7
   import display_pkg::*;
(
   input  logic [3:0] nib_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   // Decode the digit; anything outside 0-9 (unreachable) shows blank.
   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/gpio_dec_display.sv
// Watches the CPU GPIO register, converts each new value to decimal with a
// sequential shift-add-3 engine and drives eight seven-segment digits.
module gpio_dec_display
   import display_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int NDISP = 8,
   parameter bit BLANK = 1'b1
)(
   input  logic            clk,
   input  logic            res,
   input  logic [IN_W-1:0] gpio_i,
   output logic [6:0]      hex0,
   output logic [6:0]      hex1,
   output logic [6:0]      hex2,
   output logic [6:0]      hex3,
   output logic [6:0]      hex4,
   output logic [6:0]      hex5,
   output logic [6:0]      hex6,
   output logic [6:0]      hex7,
   output logic            ovf,
   output logic            busy
);

   // Decimal digits needed for an IN_W-bit number (log10(2) ~ 0.30103).
   localparam int NBCD  = (IN_W * 30103) / 100000 + 1;
   localparam int BCD_W = 4 * NBCD;
   localparam int CNT_W = $clog2(IN_W);
   localparam int MAXD  = 8;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);

   disp_state_t      state_q, state_d;
   logic [IN_W-1:0]  last_q, last_d;
   logic [IN_W-1:0]  bin_q, bin_d;
   logic [BCD_W-1:0] bcd_q, bcd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [6:0]       hex_q [MAXD];
   logic [6:0]       hex_d [MAXD];
   logic             ovf_q, ovf_d;

   logic [BCD_W-1:0] bcd_adj;
   logic [NDISP-1:0] nz_above;
   logic [6:0]       seg_w [MAXD];

   // Every nibble gets its +3 correction in parallel before the shift.
   generate
      for (genvar gi = 0; gi < NBCD; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = add3(bcd_q[4*gi +: 4]);
      end
   endgenerate

   // nz_above[k] is set when digit k or any higher displayed digit is
   // nonzero; nibbles beyond the display do not keep zeros lit.
   generate
      for (genvar gi = 0; gi < MAXD; gi++) begin : g_seg
         if (gi < NDISP) begin : g_digit
            if (gi == NDISP - 1) begin : g_top
               assign nz_above[gi] = |bcd_q[4*gi +: 4];
            end else begin : g_mid
               assign nz_above[gi] = (|bcd_q[4*gi +: 4]) | nz_above[gi+1];
            end
            bcd_seg7 u_seg (
               .nib_i   (bcd_q[4*gi +: 4]),
               .blank_i (BLANK && (gi != 0) && !nz_above[gi]),
               .seg_o   (seg_w[gi])
            );
         end else begin : g_unused
            assign seg_w[gi] = SEG_BLANK;
         end
      end
   endgenerate

   // Next-state logic for the FSM, the converter datapath and the display.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      hex_d   = hex_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            // Changes during a conversion are caught here afterwards.
            if (gpio_i != last_q) begin
               last_d  = gpio_i;
               bin_d   = gpio_i;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = CONV;
            end
         end
         CONV: begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d = LATCH;
            end
         end
         LATCH: begin
            for (int k = 0; k < MAXD; k++) begin
               hex_d[k] = seg_w[k];
            end
            ovf_d   = |bcd_q[BCD_W-1:4*NDISP];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset shows a single "0" on hex0.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= IDLE;
         last_q  <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         for (int k = 0; k < MAXD; k++) begin
            if (k == 0 || (!BLANK && k < NDISP)) begin
               hex_q[k] <= SEG_0;
            end else begin
               hex_q[k] <= SEG_BLANK;
            end
         end
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         hex_q   <= hex_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign ovf  = ovf_q;
   assign hex0 = hex_q[0];
   assign hex1 = hex_q[1];
   assign hex2 = hex_q[2];
   assign hex3 = hex_q[3];
   assign hex4 = hex_q[4];
   assign hex5 = hex_q[5];
   assign hex6 = hex_q[6];
   assign hex7 = hex_q[7];

endmodule

// File: tb/tb_gpio_dec_display.sv
// Directed checks of the GPIO decimal display: reset, conversions,
// overflow, blanking, mid-conversion input change and mid-conversion reset.
module tb_gpio_dec_display;

   logic        clk = 1'b0;
   logic        res = 1'b0;
   logic [31:0] gpio = '0;
   logic [31:0] gpio_nb = '0;

   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
   logic       ovf, busy;
   logic [6:0] nb0, nb1, nb2, nb3, nb4, nb5, nb6, nb7;
   logic       ovf_nb, busy_nb;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   gpio_dec_display #(.IN_W(32), .NDISP(8), .BLANK(1'b1)) dut (
      .clk    (clk),
      .res    (res),
      .gpio_i (gpio),
      .hex0   (hex0), .hex1 (hex1), .hex2 (hex2), .hex3 (hex3),
      .hex4   (hex4), .hex5 (hex5), .hex6 (hex6), .hex7 (hex7),
      .ovf    (ovf),
      .busy   (busy)
   );

   gpio_dec_display #(.IN_W(32), .NDISP(8), .BLANK(1'b0)) dut_nb (
      .clk    (clk),
      .res    (res),
      .gpio_i (gpio_nb),
      .hex0   (nb0), .hex1 (nb1), .hex2 (nb2), .hex3 (nb3),
      .hex4   (nb4), .hex5 (nb5), .hex6 (nb6), .hex7 (nb7),
      .ovf    (ovf_nb),
      .busy   (busy_nb)
   );

   wire [55:0] disp    = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
   wire [55:0] disp_nb = {nb7, nb6, nb5, nb4, nb3, nb2, nb1, nb0};

   localparam logic [6:0] B = 7'h7F;

   function automatic logic [55:0] mk(input logic [6:0] h7, h6, h5, h4,
                                      h3, h2, h1, h0);
      return {h7, h6, h5, h4, h3, h2, h1, h0};
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Wait (bounded) for busy to drop; returns number of edges waited.
   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Present a value, check busy rises at the load edge and the 33-edge latency.
   task automatic convert(input logic [31:0] v, input string tag);
      int n;
      @(negedge clk);
      gpio = v;
      @(posedge clk); #1;
      check_val({tag, " busy"}, busy, 1);
      wait_idle(n);
      check_val({tag, " latency"}, n, 33);
      $display("conv %s value=%0d disp=%014h ovf=%b", tag, v, disp, ovf);
   endtask

   initial begin
      int n;
      bit busy_seen;

      // Reset with gpio held at zero.
      repeat (3) @(posedge clk);
      #1;
      check_val("rst busy", busy, 0);
      @(negedge clk);
      res = 1'b1;
      busy_seen = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (busy || busy_nb) busy_seen = 1;
      end
      check_val("idle no busy", busy_seen, 0);
      check_val("rst disp", disp, mk(B, B, B, B, B, B, B, 7'h40));
      check_val("rst ovf", ovf, 0);
      check_val("rst disp noblank", disp_nb,
                mk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40));
      $display("reset disp=%014h ovf=%b", disp, ovf);

      convert(32'd12345678, "v12345678");
      check_val("v12345678 disp", disp,
                mk(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00));
      check_val("v12345678 ovf", ovf, 0);

      // 4294967295: low eight digits 9 4 9 6 7 2 9 5.
      convert(32'hFFFF_FFFF, "vmax");
      check_val("vmax disp", disp,
                mk(7'h10, 7'h19, 7'h10, 7'h02, 7'h78, 7'h24, 7'h10, 7'h12));
      check_val("vmax ovf", ovf, 1);

      convert(32'd99999999, "v99999999");
      check_val("v99999999 disp", disp,
                mk(7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10));
      check_val("v99999999 ovf", ovf, 0);

      convert(32'd100000000, "v100000000");
      check_val("v100000000 disp", disp, mk(B, B, B, B, B, B, B, 7'h40));
      check_val("v100000000 ovf", ovf, 1);

      // Input changes at CONV cycle 10; the 5 is shown, then 7 follows.
      @(negedge clk);
      gpio = 32'd5;
      @(posedge clk); #1;
      check_val("mid load busy", busy, 1);
      repeat (10) @(posedge clk);
      @(negedge clk);
      gpio = 32'd7;
      wait_idle(n);
      check_val("mid first latency", n, 23);
      check_val("mid first disp", disp, mk(B, B, B, B, B, B, B, 7'h12));
      @(posedge clk); #1;
      check_val("mid reload busy", busy, 1);
      wait_idle(n);
      check_val("mid second latency", n, 33);
      check_val("mid second disp", disp, mk(B, B, B, B, B, B, B, 7'h78));
      $display("conv mid value=7 disp=%014h ovf=%b", disp, ovf);

      convert(32'd42, "v42");
      check_val("v42 disp", disp, mk(B, B, B, B, B, B, 7'h19, 7'h24));

      // Reset during CONV cycle 15 of 1000; then 1000 converts on release.
      @(negedge clk);
      gpio = 32'd1000;
      @(posedge clk); #1;
      check_val("rstmid load busy", busy, 1);
      repeat (15) @(posedge clk);
      #2;
      res = 1'b0;
      #1;
      check_val("rstmid disp", disp, mk(B, B, B, B, B, B, B, 7'h40));
      check_val("rstmid ovf", ovf, 0);
      check_val("rstmid busy", busy, 0);
      @(negedge clk);
      res = 1'b1;
      @(posedge clk); #1;
      check_val("rstmid reload busy", busy, 1);
      wait_idle(n);
      check_val("v1000 latency", n, 33);
      check_val("v1000 disp", disp, mk(B, B, B, B, 7'h79, 7'h40, 7'h40, 7'h40));
      $display("conv v1000 value=1000 disp=%014h ovf=%b", disp, ovf);

      convert(32'd0, "v0");
      check_val("v0 disp", disp, mk(B, B, B, B, B, B, B, 7'h40));
      check_val("v0 ovf", ovf, 0);

      // No-blanking build shows leading zeros.
      @(negedge clk);
      gpio_nb = 32'd7;
      repeat (40) @(posedge clk);
      #1;
      check_val("noblank busy", busy_nb, 0);
      check_val("noblank disp", disp_nb,
                mk(7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h78));
      check_val("noblank ovf", ovf_nb, 0);
      $display("conv noblank value=7 disp=%014h ovf=%b", disp_nb, ovf_nb);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
